// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with byte FIFO
module uart_tx_mmio #(
   parameter int CLK_DIV    = 217,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic        rd_en,
   input  logic [3:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        uart_txd,
   output logic        irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          overflow, irq_en;

   state_t        state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [7:0]    shift, shift_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic          txd_n, pop;

   logic          push_req, push_ok, full, empty, busy;
   logic [4:0]    cnt_ext;
   logic [31:0]   status_word, rd_mux;
   logic          unused_bits;

   assign push_req = wr_en && (wr_addr == 4'h0);
   assign push_ok  = push_req && (count < DEPTH_C);
   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign busy     = (state != IDLE);
   assign cnt_ext  = 5'(count);
   assign status_word = {24'b0, cnt_ext[3:0], overflow, busy, empty, full};
   assign unused_bits = ^{wr_data[31:8], cnt_ext[4]};

   always_comb begin
      rd_mux = 32'b0;
      case (rd_addr)
         4'h4:    rd_mux = status_word;
         4'h8:    rd_mux = {31'b0, irq_en};
         default: rd_mux = 32'b0;
      endcase
   end

   // Each bit ends when the counter reaches zero; the counter reloads on that same cycle.
   always_comb begin
      state_n   = state;
      baud_n    = baud;
      shift_n   = shift;
      bit_idx_n = bit_idx;
      pop       = 1'b0;
      txd_n     = 1'b1;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_n = mem[rptr];
               baud_n  = BAUD_RELOAD;
               state_n = START;
            end
         end
         START: begin
            if (baud == '0) begin
               baud_n    = BAUD_RELOAD;
               bit_idx_n = 3'd0;
               state_n   = DATA;
            end else begin
               baud_n = baud - 1'b1;
            end
         end
         DATA: begin
            if (baud == '0) begin
               baud_n    = BAUD_RELOAD;
               shift_n   = {1'b0, shift[7:1]};
               bit_idx_n = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_n = STOP;
            end else begin
               baud_n = baud - 1'b1;
            end
         end
         STOP: begin
            if (baud == '0) begin
               baud_n  = BAUD_RELOAD;
               state_n = IDLE;
            end else begin
               baud_n = baud - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      case (state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = shift_n[0];
         default: txd_n = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem[wptr] <= wr_data[7:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         baud     <= '0;
         shift    <= 8'h00;
         bit_idx  <= 3'd0;
         uart_txd <= 1'b1;
         irq      <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         irq_en   <= 1'b0;
         rd_data  <= 32'b0;
      end else begin
         state    <= state_n;
         baud     <= baud_n;
         shift    <= shift_n;
         bit_idx  <= bit_idx_n;
         uart_txd <= txd_n;
         irq      <= irq_en & empty & ~busy;
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && !push_ok)
            overflow <= 1'b1;
         else if (wr_en && (wr_addr == 4'h4) && wr_data[3])
            overflow <= 1'b0;
         if (wr_en && (wr_addr == 4'h8))
            irq_en <= wr_data[0];
         if (rd_en)
            rd_data <= rd_mux;
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;

   logic        clock = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;
   logic        uart_txd;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int fall_cnt = 0;

   logic [7:0] mon_byte  [$];
   logic       mon_ok    [$];
   int         mon_start [$];

   uart_tx_mmio #(.CLK_DIV(4), .FIFO_DEPTH(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .uart_txd (uart_txd),
      .irq      (irq)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic        do_wr;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic [3:0]  ra;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs [7];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0; wr_data = 32'h0;
   endtask

   task automatic rd(input logic [3:0] a);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0;
   endtask

   // Line monitor: decodes frames by sampling mid-bit (CLK_DIV = 4)
   initial begin : mon
      logic       prev;
      logic [7:0] b;
      logic       ok;
      int         st;
      prev = 1'b1;
      forever begin
         tick();
         if (prev && !uart_txd) begin
            fall_cnt++;
            st = cyc;
            ok = 1'b1;
            repeat (2) tick();
            if (uart_txd) ok = 1'b0;
            for (int j = 0; j < 8; j++) begin
               repeat (4) tick();
               b[j] = uart_txd;
            end
            repeat (4) tick();
            if (!uart_txd) ok = 1'b0;
            mon_byte.push_back(b);
            mon_ok.push_back(ok);
            mon_start.push_back(st);
         end
         prev = uart_txd;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1);
   end

   initial begin : main
      logic [7:0] a5;
      logic       exp_bit;
      int         base, w0, f0, slot;
      logic       line_high;

      vecs[0] = '{1'b0, 4'h0, 32'h0,        4'h0, 32'h0, 1'b0};
      vecs[1] = '{1'b1, 4'h8, 32'hFFFFFFFF, 4'h8, 32'h1, 1'b1};
      vecs[2] = '{1'b1, 4'h4, 32'hFFFFFFFF, 4'h4, 32'h2, 1'b1};
      vecs[3] = '{1'b1, 4'hC, 32'hFFFFFFFF, 4'hC, 32'h0, 1'b1};
      vecs[4] = '{1'b0, 4'h0, 32'h0,        4'h1, 32'h0, 1'b1};
      vecs[5] = '{1'b1, 4'h8, 32'hFFFFFFFE, 4'h8, 32'h0, 1'b0};
      vecs[6] = '{1'b0, 4'h0, 32'h0,        4'h4, 32'h2, 1'b0};

      reset = 1'b1; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 32'h0;
      rd_en = 1'b0; rd_addr = 4'h0;
      repeat (3) tick();
      reset = 1'b0;
      check("reset_txd", 32'(uart_txd), 32'h1);
      check("reset_irq", 32'(irq), 32'h0);
      check("reset_rd_data", rd_data, 32'h0);
      rd(4'h4);
      check("reset_status", rd_data, 32'h2);

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].do_wr) wr(vecs[i].wa, vecs[i].wd);
         rd(vecs[i].ra);
         check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
         check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      end

      // Single 0xA5 frame, cycle-exact
      a5 = 8'hA5;
      wr(4'h0, 32'h000000A5);
      check("a5_pre_start", 32'(uart_txd), 32'h1);
      for (int c = 0; c < 40; c++) begin
         tick();
         slot = c / 4;
         if (slot == 0)      exp_bit = 1'b0;
         else if (slot == 9) exp_bit = 1'b1;
         else                exp_bit = a5[slot-1];
         check($sformatf("a5_cycle%0d", c), 32'(uart_txd), 32'(exp_bit));
      end
      tick();
      check("a5_idle_after", 32'(uart_txd), 32'h1);
      repeat (3) tick();

      // Ten back-to-back writes, 0x09 must overflow
      base = mon_byte.size();
      wr(4'h0, 32'h0);
      w0 = cyc;
      for (int i = 1; i < 10; i++) wr(4'h0, 32'(i));
      rd(4'h4);
      check("burst_status_full", rd_data, 32'h0000008D);
      wr(4'h4, 32'h00000008);
      rd(4'h4);
      check("burst_status_ovf_clr", rd_data, 32'h00000085);
      for (int k = 0; k < 600 && mon_byte.size() < base + 9; k++) tick();
      check("burst_frame_count", 32'(mon_byte.size() - base), 32'd9);
      if (mon_byte.size() >= base + 9) begin
         check("burst_first_start", 32'(mon_start[base]), 32'(w0 + 1));
         for (int i = 0; i < 9; i++) begin
            check($sformatf("burst_byte%0d", i), 32'(mon_byte[base+i]), 32'(i));
            check($sformatf("burst_frame_ok%0d", i), 32'(mon_ok[base+i]), 32'h1);
            if (i > 0)
               check($sformatf("burst_spacing%0d", i),
                     32'(mon_start[base+i] - mon_start[base+i-1]), 32'd41);
         end
      end
      repeat (60) tick();
      check("burst_no_tenth", 32'(mon_byte.size() - base), 32'd9);

      // irq handshake around a single frame
      wr(4'h8, 32'h1);
      tick();
      check("irq_idle_set", 32'(irq), 32'h1);
      wr(4'h0, 32'h0000003C);
      check("irq_write_edge", 32'(irq), 32'h1);
      tick();
      check("irq_after_pop", 32'(irq), 32'h0);
      repeat (40) tick();
      check("irq_at_idle_entry", 32'(irq), 32'h0);
      tick();
      check("irq_rise", 32'(irq), 32'h1);
      wr(4'h8, 32'h0);
      repeat (3) tick();

      // Reset mid-DATA with three bytes queued
      wr(4'h0, 32'h00);
      wr(4'h0, 32'h11);
      wr(4'h0, 32'h22);
      wr(4'h0, 32'h33);
      repeat (8) tick();
      check("rst_pre_txd_low", 32'(uart_txd), 32'h0);
      rd(4'h4);
      check("rst_pre_status", rd_data, 32'h00000034);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_txd", 32'(uart_txd), 32'h1);
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      rd(4'h4);
      check("rst_status", rd_data, 32'h2);
      f0 = fall_cnt;
      line_high = 1'b1;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (!uart_txd) line_high = 1'b0;
      end
      check("rst_line_high", 32'(line_high), 32'h1);
      check("rst_no_frames", 32'(fall_cnt - f0), 32'h0);
      rd(4'hC);
      check("rst_unmapped_rd", rd_data, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
